// File: rtl/maxpool_relu_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_relu_layer_pkg
// Description : Shared types, constants and index helper for the max-pool /
//               ReLU layer.
// Revision    : 1.0 - initial release
// ============================================================================
package maxpool_relu_layer_pkg;

  // Layer controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POOL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default signed sample width
  localparam int C_DATA_WIDTH_DEFAULT = 16;

  // Plane-major, row-major flat element index
  function automatic int flat_index(input int c, input int r, input int q,
                                    input int rows, input int cols);
    return (c * rows + r) * cols + q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_relu_layer_pool_window_max.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_max
// Description : Combinational signed maximum over a PxP window with an
//               optional clamp of negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_max #(
  parameter int DATA_WIDTH = 16,
  parameter int P          = 2
) (
  input  logic [0:P*P*DATA_WIDTH-1]    window,
  input  logic                         relu_en,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [DATA_WIDTH-1:0] w_max;
  logic signed [DATA_WIDTH-1:0] w_sample;

  // Linear scan for the largest window sample, then optional clamp at zero
  always_comb begin
    w_max    = window[0 +: DATA_WIDTH];
    w_sample = '0;
    for (int k = 1; k < P * P; k++) begin
      w_sample = window[k*DATA_WIDTH +: DATA_WIDTH];
      if (w_sample > w_max) begin
        w_max = w_sample;
      end
    end
    result = (relu_en && w_max[DATA_WIDTH-1]) ? '0 : w_max;
  end

endmodule
`default_nettype wire

// File: rtl/maxpool_relu_layer.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_relu_layer
// Description : Latches an image, then produces one pooled (and optionally
//               ReLU-clamped) output element per cycle into a registered
//               output array. Trailing rows/columns not covered by a full
//               window are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_relu_layer
  import maxpool_relu_layer_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH_DEFAULT,
  parameter int D          = 6,
  parameter int H          = 28,
  parameter int W          = 28,
  parameter int P          = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               relu_en,
  input  logic [0:D*H*W*DATA_WIDTH-1]        image,
  output logic                               busy,
  output logic                               done,
  output logic [0:D*(H/P)*(W/P)*DATA_WIDTH-1] outputPool
);

  localparam int HO = H / P;
  localparam int WO = W / P;
  localparam int CW = (D  > 1) ? $clog2(D)  : 1;
  localparam int RW = (HO > 1) ? $clog2(HO) : 1;
  localparam int QW = (WO > 1) ? $clog2(WO) : 1;

  state_t                            r_state;
  logic [0:D*H*W*DATA_WIDTH-1]       r_image;
  logic                              r_relu;
  logic [CW-1:0]                     r_c;
  logic [RW-1:0]                     r_r;
  logic [QW-1:0]                     r_q;
  logic [0:D*HO*WO*DATA_WIDTH-1]     r_out;
  logic                              r_busy;
  logic                              r_done;

  logic [0:P*P*DATA_WIDTH-1]         w_window;
  logic signed [DATA_WIDTH-1:0]      w_result;
  int                                w_idx;
  int                                w_n;
  logic                              w_q_wrap;
  logic                              w_r_wrap;
  logic                              w_last;

  assign busy       = r_busy;
  assign done       = r_done;
  assign outputPool = r_out;

  // Gather the PxP window of latched samples addressed by the counters
  always_comb begin
    w_window = '0;
    w_idx    = 0;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < P; j++) begin
        w_idx = flat_index(int'(r_c), int'(r_r) * P + i, int'(r_q) * P + j, H, W);
        w_window[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] = r_image[w_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output slot and counter wrap conditions for the current element
  always_comb begin
    w_n      = flat_index(int'(r_c), int'(r_r), int'(r_q), HO, WO);
    w_q_wrap = (int'(r_q) == WO - 1);
    w_r_wrap = (int'(r_r) == HO - 1);
    w_last   = w_q_wrap && w_r_wrap && (int'(r_c) == D - 1);
  end

  pool_window_max #(
    .DATA_WIDTH (DATA_WIDTH),
    .P          (P)
  ) u_pool_window_max (
    .window  (w_window),
    .relu_en (r_relu),
    .result  (w_result)
  );

  // Controller: accept/latch, per-cycle element write, counter walk, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_image <= '0;
      r_relu  <= 1'b0;
      r_c     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_image <= image;
            r_relu  <= relu_en;
            r_out   <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_POOL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_POOL: begin
          r_out[w_n*DATA_WIDTH +: DATA_WIDTH] <= w_result;
          if (w_last) begin
            r_c     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_q_wrap) begin
            r_q <= '0;
            if (w_r_wrap) begin
              r_r <= '0;
              r_c <= r_c + 1'b1;
            end else begin
              r_r <= r_r + 1'b1;
            end
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_relu_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool_relu_layer
// Description : Directed bench for maxpool_relu_layer using three layer
//               geometries (1x4x4, 1x5x5, 2x4x4) with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_relu_layer;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;

  logic                start0, relu0, busy0, done0;
  logic [0:16*DW-1]    img0;
  logic [0:4*DW-1]     out0;

  logic                start1, relu1, busy1, done1;
  logic [0:25*DW-1]    img1;
  logic [0:4*DW-1]     out1;

  logic                start2, relu2, busy2, done2;
  logic [0:32*DW-1]    img2;
  logic [0:8*DW-1]     out2;

  int checks   = 0;
  int failures = 0;

  int bc, dc, fd, ld;

  always #5 clk = ~clk;

  maxpool_relu_layer #(.DATA_WIDTH(DW), .D(1), .H(4), .W(4), .P(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .relu_en(relu0),
    .image(img0), .busy(busy0), .done(done0), .outputPool(out0));

  maxpool_relu_layer #(.DATA_WIDTH(DW), .D(1), .H(5), .W(5), .P(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .relu_en(relu1),
    .image(img1), .busy(busy1), .done(done1), .outputPool(out1));

  maxpool_relu_layer #(.DATA_WIDTH(DW), .D(2), .H(4), .W(4), .P(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .relu_en(relu2),
    .image(img2), .busy(busy2), .done(done2), .outputPool(out2));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:4*DW-1] pack4(input int a, input int b, input int c, input int d);
    return {DW'(a), DW'(b), DW'(c), DW'(d)};
  endfunction

  // Pulse start for one edge; returns at the falling edge after the accept edge
  task automatic accept(input int sel);
    @(negedge clk);
    case (sel)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    case (sel)
      0: start0 = 1'b0;
      1: start1 = 1'b0;
      default: start2 = 1'b0;
    endcase
  endtask

  // Sample busy/done after edges k=1..ncyc (k=1 is the accept edge);
  // optionally drives start high for the edge following sample pulse_at
  task automatic watch(input int sel, input int ncyc, input int pulse_at,
                       output int b_cnt, output int d_cnt,
                       output int first_d, output int last_d);
    logic b, d;
    b_cnt = 0; d_cnt = 0; first_d = -1; last_d = -1;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) @(negedge clk);
      case (sel)
        0: begin b = busy0; d = done0; end
        1: begin b = busy1; d = done1; end
        default: begin b = busy2; d = done2; end
      endcase
      if (b) b_cnt++;
      if (d) begin
        d_cnt++;
        if (first_d < 0) first_d = k;
        last_d = k;
      end
      case (sel)
        0: start0 = (k == pulse_at);
        1: start1 = (k == pulse_at);
        default: start2 = (k == pulse_at);
      endcase
    end
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    relu0  = 1'b0; relu1  = 1'b0; relu2  = 1'b0;
    img0 = '0; img1 = '0; img2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", 128'(busy0), 128'(0));
    check("reset_done", 128'(done0), 128'(0));
    check("reset_out",  128'(out0),  128'(0));
    reset = 1'b0;

    // Ramp 0..15, no clamp
    for (int k = 0; k < 16; k++) img0[k*DW +: DW] = DW'(k);
    relu0 = 1'b0;
    accept(0);
    watch(0, 7, 0, bc, dc, fd, ld);
    check("ramp_out",     128'(out0), 128'(pack4(5, 7, 13, 15)));
    check("ramp_busy",    128'(bc), 128'(4));
    check("ramp_done_at", 128'(fd), 128'(5));
    check("ramp_done_n",  128'(dc), 128'(1));

    // Negative samples, one larger value at sample 5
    for (int k = 0; k < 16; k++) img0[k*DW +: DW] = DW'(-3);
    img0[5*DW +: DW] = DW'(-1);
    relu0 = 1'b0;
    accept(0);
    watch(0, 7, 0, bc, dc, fd, ld);
    check("neg_out", 128'(out0), 128'(pack4(-1, -3, -3, -3)));
    relu0 = 1'b1;
    accept(0);
    watch(0, 7, 0, bc, dc, fd, ld);
    check("neg_relu_out", 128'(out0), 128'(pack4(0, 0, 0, 0)));
    relu0 = 1'b0;

    // Start re-pulsed during POOL with a different image is ignored
    for (int k = 0; k < 16; k++) img0[k*DW +: DW] = DW'(k);
    accept(0);
    for (int k = 0; k < 16; k++) img0[k*DW +: DW] = DW'(50);
    watch(0, 8, 2, bc, dc, fd, ld);
    check("restart_out",     128'(out0), 128'(pack4(5, 7, 13, 15)));
    check("restart_done_n",  128'(dc), 128'(1));
    check("restart_done_at", 128'(fd), 128'(5));

    // Reset during POOL aborts the run
    for (int k = 0; k < 16; k++) img0[k*DW +: DW] = DW'(k);
    accept(0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 128'(busy0), 128'(0));
    check("abort_out",  128'(out0),  128'(0));
    check("abort_done", 128'(done0), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    watch(0, 8, 0, bc, dc, fd, ld);
    check("abort_no_done", 128'(dc), 128'(0));
    check("abort_idle",    128'(bc), 128'(0));
    accept(0);
    watch(0, 7, 0, bc, dc, fd, ld);
    check("abort_rerun_out",  128'(out0), 128'(pack4(5, 7, 13, 15)));
    check("abort_rerun_done", 128'(fd), 128'(5));

    // 5x5 plane: last row and column fall outside any window
    for (int k = 0; k < 25; k++) img1[k*DW +: DW] = DW'(k);
    accept(1);
    watch(1, 7, 0, bc, dc, fd, ld);
    check("odd_out",     128'(out1), 128'(pack4(6, 8, 16, 18)));
    check("odd_done_at", 128'(fd), 128'(5));

    // Two planes, second start accepted in the DONE cycle of a zero-image run
    img2 = '0;
    accept(2);
    for (int k = 0; k < 16; k++) begin
      img2[k*DW +: DW]      = DW'(k);
      img2[(16+k)*DW +: DW] = DW'(k + 100);
    end
    watch(2, 20, 9, bc, dc, fd, ld);
    check("dual_out", 128'(out2),
          128'({pack4(5, 7, 13, 15), pack4(105, 107, 113, 115)}));
    check("dual_done_n",    128'(dc), 128'(2));
    check("dual_first_done", 128'(fd), 128'(9));
    check("dual_last_done",  128'(ld), 128'(18));
    check("dual_busy",       128'(bc), 128'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
